// File: rtl/button_event_sequencer.sv
// rtl/button_event_sequencer.sv - debounced button press/release events, granted one per cycle round-robin
module button_event_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [6:0] btn_i,
   input  logic       en_i,
   input  logic       clr_i,
   output logic [6:0] press_o,
   output logic [6:0] release_o,
   output logic       valid_o,
   output logic       overrun_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [6:0]    sync1_q;
   logic [6:0]    sync2_q;
   logic [6:0]    stable_q;
   logic [CW-1:0] cnt_q [7];
   logic [6:0]    toggle;
   logic [6:0]    rise;
   logic [6:0]    fall;

   logic [6:0]    pend_press_q;
   logic [6:0]    pend_rel_q;
   logic [6:0]    any_pend;
   logic [2:0]    rr_q;
   logic [2:0]    sel_idx;
   logic [2:0]    rr_next;
   logic          sel_found;
   logic [3:0]    cand;
   logic [6:0]    sel_onehot;
   logic [6:0]    gnt_press;
   logic [6:0]    gnt_rel;
   logic          gnt_valid;
   logic          overrun_set;
   logic [6:0]    gnt_press_q;
   logic [6:0]    gnt_rel_q;

   // A button flips its debounced level on the edge its mismatch run would reach DEBOUNCE_CYCLES.
   always_comb begin
      toggle = '0;
      for (int i = 0; i < 7; i++) begin
         toggle[i] = (sync2_q[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
      end
   end

   assign rise = toggle & ~stable_q;
   assign fall = toggle & stable_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < 7; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_q ^ toggle;
         for (int i = 0; i < 7; i++) begin
            if ((sync2_q[i] == stable_q[i]) || toggle[i]) begin
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign any_pend = pend_press_q | pend_rel_q;

   // Search from rr_q upward, wrapping at 7, for the first button with anything pending.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < 7; k++) begin
         cand = {1'b0, rr_q} + 4'(k);
         if (cand >= 4'd7) begin
            cand = cand - 4'd7;
         end
         if (!sel_found && any_pend[cand[2:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[2:0];
         end
      end
   end

   assign gnt_valid = en_i & sel_found;
   assign rr_next   = (sel_idx == 3'd6) ? 3'd0 : sel_idx + 3'd1;

   // Press is always served before release for the same button.
   always_comb begin
      gnt_press  = '0;
      gnt_rel    = '0;
      sel_onehot = 7'b1 << sel_idx;
      if (gnt_valid) begin
         if (pend_press_q[sel_idx]) begin
            gnt_press = sel_onehot;
         end else begin
            gnt_rel = sel_onehot;
         end
      end
   end

   assign overrun_set = |((rise & pend_press_q & ~gnt_press) |
                          (fall & pend_rel_q & ~gnt_rel));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pend_press_q <= '0;
         pend_rel_q   <= '0;
         rr_q         <= '0;
         gnt_press_q  <= '0;
         gnt_rel_q    <= '0;
         press_o      <= '0;
         release_o    <= '0;
         valid_o      <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         pend_press_q <= (pend_press_q & ~gnt_press) | rise;
         pend_rel_q   <= (pend_rel_q & ~gnt_rel) | fall;
         if (gnt_valid) begin
            rr_q <= rr_next;
         end
         gnt_press_q <= gnt_press;
         gnt_rel_q   <= gnt_rel;
         press_o     <= gnt_press_q;
         release_o   <= gnt_rel_q;
         valid_o     <= |(gnt_press_q | gnt_rel_q);
         overrun_o   <= overrun_set | (overrun_o & ~clr_i);
      end
   end

endmodule

// File: tb/tb_button_event_sequencer.sv
// tb/tb_button_event_sequencer.sv - vector table, reset sequences and random traffic against an event-level model
module tb_button_event_sequencer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] btn;
   logic       en;
   logic       clr;
   logic [6:0] press_o;
   logic [6:0] release_o;
   logic       valid_o;
   logic       overrun_o;

   always #5 clk = ~clk;

   button_event_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .btn_i     (btn),
      .en_i      (en),
      .clr_i     (clr),
      .press_o   (press_o),
      .release_o (release_o),
      .valid_o   (valid_o),
      .overrun_o (overrun_o)
   );

   int checks = 0;
   int errors = 0;

   // Model: sampled-input history, accepted levels, pending events, last grant and visible output.
   int m_s1[7], m_s2[7], m_st[7], m_run[7], m_pp[7], m_pr[7];
   int m_rr, m_gb, m_gk, m_ob, m_ok, m_ovr;

   typedef struct {
      logic [6:0] btn;
      logic       en;
      logic       clr;
      int         n;
      logic [6:0] ep;
      logic [6:0] er;
      logic       eo;
   } vec_t;

   vec_t       tbl[$];
   logic [6:0] rb;
   int         en_mode;

   function automatic void model_reset();
      for (int i = 0; i < 7; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0; m_pp[i] = 0; m_pr[i] = 0;
      end
      m_rr = 0; m_gb = -1; m_gk = 0; m_ob = -1; m_ok = 0; m_ovr = 0;
   endfunction

   function automatic void model_step(input logic [6:0] b, input logic e, input logic c);
      int gb;
      int lost;
      m_ob = m_gb;
      m_ok = m_gk;
      gb = -1;
      if (e) begin
         for (int k = 0; k < 7; k++) begin
            if (gb < 0 && (m_pp[(m_rr + k) % 7] != 0 || m_pr[(m_rr + k) % 7] != 0)) gb = (m_rr + k) % 7;
         end
      end
      m_gb = gb;
      if (gb >= 0) begin
         m_gk = (m_pp[gb] != 0) ? 0 : 1;
         if (m_gk == 0) m_pp[gb] = 0; else m_pr[gb] = 0;
         m_rr = (gb + 1) % 7;
      end
      lost = 0;
      for (int i = 0; i < 7; i++) begin
         if (m_s2[i] == m_st[i]) begin
            m_run[i] = 0;
         end else begin
            m_run[i]++;
            if (m_run[i] == D) begin
               m_run[i] = 0;
               m_st[i]  = 1 - m_st[i];
               if (m_st[i] == 1) begin
                  if (m_pp[i] != 0) lost = 1;
                  m_pp[i] = 1;
               end else begin
                  if (m_pr[i] != 0) lost = 1;
                  m_pr[i] = 1;
               end
            end
         end
      end
      if (lost != 0) m_ovr = 1;
      else if (c) m_ovr = 0;
      for (int i = 0; i < 7; i++) begin
         m_s2[i] = m_s1[i];
         m_s1[i] = int'(b[i]);
      end
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [6:0] ep;
      logic [6:0] er;
      ep = (m_ob >= 0 && m_ok == 0) ? 7'(1 << m_ob) : 7'd0;
      er = (m_ob >= 0 && m_ok == 1) ? 7'(1 << m_ob) : 7'd0;
      check("model_press", press_o, ep);
      check("model_release", release_o, er);
      check("model_valid", {6'd0, valid_o}, {6'd0, (m_ob >= 0)});
      check("model_overrun", {6'd0, overrun_o}, 7'(m_ovr));
   endtask

   task automatic tick(input logic [6:0] b, input logic e, input logic c);
      btn = b; en = e; clr = c;
      @(posedge clk);
      if (reset) model_reset();
      else model_step(b, e, c);
      @(negedge clk);
      model_check();
   endtask

   function automatic void add(input logic [6:0] b, input logic e, input logic c, input int n,
                               input logic [6:0] ep, input logic [6:0] er, input logic eo);
      vec_t v;
      v.btn = b; v.en = e; v.clr = c; v.n = n; v.ep = ep; v.er = er; v.eo = eo;
      tbl.push_back(v);
   endfunction

   initial begin
      reset = 1'b1; btn = '0; en = 1'b0; clr = 1'b0;
      model_reset();
      @(negedge clk);
      tick(7'h00, 1'b0, 1'b0);
      check("reset_press", press_o, 7'h00);
      check("reset_overrun", {6'd0, overrun_o}, 7'h00);
      reset = 1'b0;

      // Isolated press/release latency, glitch, all-at-once, en-gated, overrun merge.
      add(7'h00, 1, 0, 3, 7'h00, 7'h00, 0);
      add(7'h40, 1, 0, 7, 7'h00, 7'h00, 0);
      add(7'h40, 1, 0, 1, 7'h40, 7'h00, 0);
      add(7'h40, 1, 0, 1, 7'h00, 7'h00, 0);
      add(7'h00, 1, 0, 7, 7'h00, 7'h00, 0);
      add(7'h00, 1, 0, 1, 7'h00, 7'h40, 0);
      add(7'h00, 1, 0, 1, 7'h00, 7'h00, 0);
      add(7'h40, 1, 0, 3, 7'h00, 7'h00, 0);
      add(7'h00, 1, 0, 10, 7'h00, 7'h00, 0);
      add(7'h7F, 1, 0, 7, 7'h00, 7'h00, 0);
      for (int j = 0; j < 7; j++) add(7'h7F, 1, 0, 1, 7'(1 << j), 7'h00, 0);
      add(7'h7F, 1, 0, 1, 7'h00, 7'h00, 0);
      add(7'h00, 1, 0, 7, 7'h00, 7'h00, 0);
      for (int j = 0; j < 7; j++) add(7'h00, 1, 0, 1, 7'h00, 7'(1 << j), 0);
      add(7'h00, 1, 0, 1, 7'h00, 7'h00, 0);
      add(7'h01, 0, 0, 10, 7'h00, 7'h00, 0);
      add(7'h00, 0, 0, 10, 7'h00, 7'h00, 0);
      add(7'h00, 1, 0, 1, 7'h00, 7'h00, 0);
      add(7'h00, 1, 0, 1, 7'h01, 7'h00, 0);
      add(7'h00, 1, 0, 1, 7'h00, 7'h01, 0);
      add(7'h00, 1, 0, 1, 7'h00, 7'h00, 0);
      add(7'h04, 0, 0, 8, 7'h00, 7'h00, 0);
      add(7'h00, 0, 0, 8, 7'h00, 7'h00, 0);
      add(7'h04, 0, 0, 8, 7'h00, 7'h00, 1);
      add(7'h04, 1, 0, 1, 7'h00, 7'h00, 1);
      add(7'h04, 1, 0, 1, 7'h04, 7'h00, 1);
      add(7'h04, 1, 0, 1, 7'h00, 7'h04, 1);
      add(7'h04, 1, 0, 1, 7'h00, 7'h00, 1);
      add(7'h04, 1, 1, 1, 7'h00, 7'h00, 0);
      add(7'h04, 1, 0, 1, 7'h00, 7'h00, 0);
      add(7'h00, 1, 0, 7, 7'h00, 7'h00, 0);
      add(7'h00, 1, 0, 1, 7'h00, 7'h04, 0);
      add(7'h00, 1, 0, 1, 7'h00, 7'h00, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int c = 0; c < tbl[i].n; c++) tick(tbl[i].btn, tbl[i].en, tbl[i].clr);
         check($sformatf("vec%0d_press", i), press_o, tbl[i].ep);
         check($sformatf("vec%0d_release", i), release_o, tbl[i].er);
         check($sformatf("vec%0d_valid", i), {6'd0, valid_o}, {6'd0, |(tbl[i].ep | tbl[i].er)});
         check($sformatf("vec%0d_overrun", i), {6'd0, overrun_o}, {6'd0, tbl[i].eo});
      end

      // Reset with events pending, an output pulse live, overrun set and button 1 mid-debounce.
      repeat (8) tick(7'h08, 1'b0, 1'b0);
      repeat (8) tick(7'h00, 1'b0, 1'b0);
      repeat (8) tick(7'h08, 1'b0, 1'b0);
      repeat (2) tick(7'h0A, 1'b1, 1'b0);
      check("pre_reset_press", press_o, 7'h08);
      check("pre_reset_overrun", {6'd0, overrun_o}, 7'h01);
      #2 reset = 1'b1;
      #1;
      check("async_reset_press", press_o, 7'h00);
      check("async_reset_release", release_o, 7'h00);
      check("async_reset_valid", {6'd0, valid_o}, 7'h00);
      check("async_reset_overrun", {6'd0, overrun_o}, 7'h00);
      model_reset();
      @(negedge clk);
      tick(7'h0A, 1'b1, 1'b0);
      reset = 1'b0;
      tick(7'h0A, 1'b1, 1'b0);
      check("post_reset_first_valid", {6'd0, valid_o}, 7'h00);
      repeat (6) tick(7'h0A, 1'b1, 1'b0);
      check("held_press_quiet", {6'd0, valid_o}, 7'h00);
      tick(7'h0A, 1'b1, 1'b0);
      check("held_press_b1", press_o, 7'h02);
      tick(7'h0A, 1'b1, 1'b0);
      check("held_press_b3", press_o, 7'h08);

      // Random traffic: sticky button walks, enable phases, rare clears and resets.
      rb = 7'h0A;
      en_mode = 1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 40 == 0) en_mode = int'($urandom_range(0, 2));
         for (int i = 0; i < 7; i++) begin
            if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
         end
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b1;
            tick(rb, 1'b1, 1'b0);
            reset = 1'b0;
         end else begin
            tick(rb, (en_mode == 0) ? 1'b0 : (en_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_event_sequencer.md
BUTTON_EVENT_SEQUENCER -- requirements
Module: button_event_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4 (legal 1..255); consecutive cycles a synchronized level must differ before it is accepted.
REQ-002 SHALL have port clk_i, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port reset_i, input, 1; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port btn_i, input, 7, raw button levels, bit map [0]=up [1]=down [2]=left [3]=right [4]=b [5]=a [6]=start, 1=pressed.
REQ-005 SHALL have port en_i, input, 1, grant enable from the downstream cheat-code detector.
REQ-006 SHALL have port clr_i, input, 1, synchronous clear of overrun_o.
REQ-007 SHALL have port press_o, output, 7, registered one-cycle press pulses, btn_i bit map.
REQ-008 SHALL have port release_o, output, 7, registered one-cycle release pulses, btn_i bit map.
REQ-009 SHALL have port valid_o, output, 1, OR of press_o and release_o.
REQ-010 SHALL have port overrun_o, output, 1, sticky lost-event flag.

Function
REQ-011 SHALL pass each btn_i bit through a 2-flop synchronizer.
REQ-012 SHALL keep per button a debounced level stable_q and a mismatch counter, width clog2(DEBOUNCE_CYCLES+1).
REQ-013 SHALL clear the counter in any cycle where synchronized level equals stable_q.
REQ-014 SHALL increment the counter on mismatch; on the edge where it would reach DEBOUNCE_CYCLES, toggle stable_q and clear the counter.
REQ-015 SHALL, on the edge stable_q goes 0->1, set pend_press[i]; on 1->0, set pend_rel[i].
REQ-016 SHALL set overrun_o when a pending flag is set while already set and not granted that same edge; the new event merges into the existing one.
REQ-017 SHALL, when a flag is granted and re-set on the same edge, leave it set and not flag overrun.
REQ-018 SHALL, when en_i=1 and any flag pending, grant exactly one event per cycle; none when en_i=0.
REQ-019 SHALL select the button by round-robin: lowest index at or after pointer rr_q (mod 7) with any pending flag.
REQ-020 SHALL, for the selected button, grant press if pend_press set, otherwise release (press-before-release order per button).
REQ-021 SHALL, on grant, clear the granted flag and set rr_q to granted index+1 mod 7; rr_q holds otherwise.
REQ-022 SHALL register the grant into press_o/release_o the following edge; at most one bit of the 14 high in any cycle.
REQ-023 SHALL drive press_o, release_o, valid_o to 0 in every cycle following an edge with no grant.
REQ-024 SHALL produce, for a clean isolated change with en_i=1 and no contention, the pulse exactly DEBOUNCE_CYCLES+3 cycles after the first btn_i sampling edge.
REQ-025 SHALL hold pending flags and keep debouncing while en_i=0.
REQ-026 SHALL clear overrun_o on clr_i=1 unless a new overrun occurs same edge (set wins).

Reset
REQ-027 SHALL on reset_i=1 asynchronously clear synchronizers, stable_q, counters, pending flags, rr_q, and all outputs to 0.
REQ-028 SHALL treat buttons held across reset release as new presses, debounced normally.
REQ-029 SHALL discard all pending events on reset mid-operation; no pulse in the first cycle after deassertion.

Verification
REQ-030 SHALL cover: DEBOUNCE_CYCLES=4, en_i=1, btn_i[6] 0->1 held -> press_o=7'h40 for one cycle exactly 7 cycles later; later release -> release_o=7'h40 after 7 cycles.
REQ-031 SHALL cover: btn_i[6] high for 3 cycles then low (glitch) -> no pulse, overrun_o=0.
REQ-032 SHALL cover: btn_i 0->7'h7F in one cycle, en_i=1, rr_q=0 -> press_o 01,02,04,08,10,20,40 on 7 consecutive cycles.
REQ-033 SHALL cover: en_i=0, press and release of button 0 debounced -> en_i=1 yields press_o=01 then release_o=01 next cycle, overrun_o=0.
REQ-034 SHALL cover: en_i=0, press/release/press of button 2 -> overrun_o=1, single press then release on en_i=1; clr_i pulse -> overrun_o=0.
REQ-035 SHALL cover: reset_i asserted mid-debounce and with events pending -> all outputs 0 immediately; no pulses until a new debounced change.
